// File: rtl/sig_norm_round.sv
// sig_norm_round: post-add normalize-and-round stage of the binary64 adder.
//
// Takes the significand adder's magnitude, zero flag, result sign and the
// pre-normalization exponent. It normalizes with an iterative shifter, rounds
// in one of the four IEEE-754 directed/nearest modes, and returns a packed
// binary64 result with flags over a valid/ready handshake.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   stage idle and able to accept an operand
//   fs         57-bit magnitude: bit56 weight 2, bit55 weight 1, bits 2..0 g/r/s
//   fszero     sum is exactly zero
//   ss1        result sign
//   sx         effective subtraction (selects the sign of an exact zero)
//   es         biased exponent of fs at the bit55 weight (two's complement)
//   rm         rounding mode: 00 RNE, 01 RTZ, 10 RU, 11 RD
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     packed binary64 result
//   inexact    rounding discarded nonzero bits
//   overflow   result exceeded max finite
//   underflow  result tiny and inexact
module sig_norm_round #(
   parameter int unsigned EW        = 13,
   parameter int unsigned BIG_SHIFT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [56:0]   fs,
   input  logic          fszero,
   input  logic          ss1,
   input  logic          sx,
   input  logic [EW-1:0] es,
   input  logic [1:0]    rm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   result,
   output logic          inexact,
   output logic          overflow,
   output logic          underflow
);

   localparam logic signed [EW-1:0] EOne  = EW'(1);
   localparam logic signed [EW-1:0] EBig  = EW'(BIG_SHIFT);
   localparam logic signed [EW-1:0] EMax  = EW'(2047);

   typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

   state_e               state;
   logic [56:0]          sig;
   logic signed [EW-1:0] e;
   logic                 sign;
   logic                 zero;
   logic [1:0]           mode;

   logic signed [EW-1:0] e_big;

   logic                 r_g;
   logic                 r_st;
   logic                 r_inc;
   logic [53:0]          r_sum;
   logic [52:0]          r_mant;
   logic signed [EW-1:0] r_e;
   logic                 r_ovf;
   logic                 r_inf;
   logic [10:0]          r_expf;
   logic [63:0]          r_res;
   logic                 r_inx;
   logic                 r_unf;

   assign e_big = e - EBig;

   // Rounding datapath, evaluated from the normalized significand in ROUND.
   always_comb begin
      r_g  = sig[2];
      r_st = sig[1] | sig[0];
      case (mode)
         2'b00:   r_inc = r_g & (r_st | sig[3]);
         2'b01:   r_inc = 1'b0;
         2'b10:   r_inc = (r_g | r_st) & ~sign;
         default: r_inc = (r_g | r_st) & sign;
      endcase
      r_sum  = {1'b0, sig[55:3]} + {53'd0, r_inc};
      r_mant = r_sum[52:0];
      r_e    = e;
      if (r_sum[53]) begin
         // Mantissa of all ones rounded up: renormalize.
         r_mant = r_sum[53:1];
         r_e    = e + EOne;
      end else if (!sig[55] && r_sum[52]) begin
         // Denormal rounded up into the hidden bit becomes the smallest normal.
         r_e = EOne;
      end
      r_inx  = r_g | r_st;
      r_ovf  = (r_e >= EMax);
      r_inf  = (mode == 2'b00) || (mode == 2'b10 && !sign) || (mode == 2'b11 && sign);
      r_expf = r_mant[52] ? r_e[10:0] : 11'd0;
      r_unf  = 1'b0;
      if (r_ovf) begin
         r_res = r_inf ? {sign, 11'h7ff, 52'd0} : {sign, 63'h7fef_ffff_ffff_ffff};
         r_inx = 1'b1;
      end else begin
         r_res = {sign, r_expf, r_mant[51:0]};
         r_unf = (r_expf == 11'd0) & r_inx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= 64'd0;
         inexact   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         sig       <= '0;
         e         <= '0;
         sign      <= 1'b0;
         zero      <= 1'b0;
         mode      <= 2'b00;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid) begin
                  sig      <= fs;
                  e        <= es;
                  mode     <= rm;
                  zero     <= fszero;
                  // An exact zero from a cancelling subtraction is -0 only in RD.
                  sign     <= (fszero && sx) ? (rm == 2'b11) : ss1;
                  in_ready <= 1'b0;
                  // A zero skips normalization; ROUND emits it one cycle later.
                  state    <= fszero ? StRound : StNorm;
               end
            end
            StNorm: begin
               if (sig[56]) begin
                  sig   <= {1'b0, sig[56:2], sig[1] | sig[0]};
                  e     <= e + EOne;
                  state <= StRound;
               end else if (sig[55]) begin
                  state <= StRound;
               end else if (e <= EOne) begin
                  // Cannot shift further without going below the minimum exponent.
                  state <= StRound;
               end else if (sig[55 -: BIG_SHIFT] == '0 && e_big >= EOne) begin
                  sig <= sig << BIG_SHIFT;
                  e   <= e_big;
               end else begin
                  sig <= sig << 1;
                  e   <= e - EOne;
               end
            end
            StRound: begin
               if (zero) begin
                  result    <= {sign, 63'd0};
                  inexact   <= 1'b0;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
               end else begin
                  result    <= r_res;
                  inexact   <= r_inx;
                  overflow  <= r_ovf;
                  underflow <= r_unf;
               end
               out_valid <= 1'b1;
               state     <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sig_norm_round.sv
// Directed plus randomized bench for sig_norm_round with a value-level
// reference model of the normalize/round rules.
module tb_sig_norm_round;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [56:0] fs;
   logic        fszero;
   logic        ss1;
   logic        sx;
   logic [12:0] es;
   logic [1:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        inexact;
   logic        overflow;
   logic        underflow;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sig_norm_round #(.EW(13), .BIG_SHIFT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fs        (fs),
      .fszero    (fszero),
      .ss1       (ss1),
      .sx        (sx),
      .es        (es),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .inexact   (inexact),
      .overflow  (overflow),
      .underflow (underflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: value of the operand, shifted per the rules, then rounded
   // with integer arithmetic on the 53-bit mantissa. Flags = {inexact, ovf, unf}.
   function automatic void model(input logic [56:0] f, input bit z, input bit ss, input bit sxv,
                                 input logic [12:0] ex, input logic [1:0] m,
                                 output logic [63:0] r, output logic [2:0] fl, output int lat);
      logic [56:0] s;
      logic [63:0] mant;
      int          e;
      bit          sgn, g, st, inc, inx, denorm;
      logic [10:0] ef;
      if (z) begin
         sgn = sxv ? (m == 2'b11) : ss;
         r   = {sgn, 63'd0};
         fl  = 3'b000;
         lat = 1;
         return;
      end
      sgn = ss;
      s   = f;
      e   = int'($signed(ex));
      lat = 2;
      forever begin
         if (s[56]) begin
            st = s[0];
            s  = s >> 1;
            s[0] = s[0] | st;
            e++;
            break;
         end
         if (s[55] || e <= 1) break;
         if (s[55:48] == 8'd0 && e - 8 >= 1) begin
            s = s << 8;
            e -= 8;
         end else begin
            s = s << 1;
            e -= 1;
         end
         lat++;
      end
      denorm = !s[55];
      mant = 64'd0;
      mant[52:0] = s[55:3];
      g  = s[2];
      st = s[1] | s[0];
      case (m)
         2'b00:   inc = g && (st || mant[0]);
         2'b01:   inc = 1'b0;
         2'b10:   inc = (g || st) && !sgn;
         default: inc = (g || st) && sgn;
      endcase
      inx  = g || st;
      mant = mant + 64'(inc);
      if (mant >= 64'h0020_0000_0000_0000) begin
         mant = mant >> 1;
         e++;
      end else if (denorm && mant >= 64'h0010_0000_0000_0000) begin
         e = 1;
      end
      if (e >= 2047) begin
         if (m == 2'b00 || (m == 2'b10 && !sgn) || (m == 2'b11 && sgn))
            r = {sgn, 63'h7ff0_0000_0000_0000};
         else
            r = {sgn, 63'h7fef_ffff_ffff_ffff};
         fl = 3'b110;
      end else begin
         ef = (mant >= 64'h0010_0000_0000_0000) ? 11'(e) : 11'd0;
         r  = {sgn, ef, mant[51:0]};
         fl = {inx, 1'b0, (ef == 11'd0) && inx};
      end
   endfunction

   task automatic do_op(input string tag, input logic [56:0] f, input bit z, input bit ss,
                        input bit sxv, input logic [12:0] ex, input logic [1:0] m,
                        input int hold, input bit early);
      logic [63:0] er;
      logic [2:0]  ef;
      int          el;
      int          n;
      model(f, z, ss, sxv, ex, m, er, ef, el);
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
      fs = f; fszero = z; ss1 = ss; sx = sxv; es = ex; rm = m;
      in_valid = 1'b1;
      out_ready = early;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "/in_ready_busy"}, 64'(in_ready), 64'd0);
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "/latency"}, 64'(n), 64'(el));
      check({tag, "/result"}, result, er);
      check({tag, "/flags"}, 64'({inexact, overflow, underflow}), 64'(ef));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "/hold_result"}, result, er);
         check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
      check({tag, "/in_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [56:0] f;
      logic [56:0] mask;
      logic [12:0] ex;
      int          pos;
      int          seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      fs = '0; fszero = 1'b0; ss1 = 1'b0; sx = 1'b0; es = '0; rm = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      check("reset/in_ready", 64'(in_ready), 64'd1);
      check("reset/out_valid", 64'(out_valid), 64'd0);
      check("reset/result", result, 64'd0);
      check("reset/flags", 64'({inexact, overflow, underflow}), 64'd0);

      do_op("two", 57'd1 << 56, 1'b0, 1'b0, 1'b0, 13'd1023, 2'b00, 0, 1'b0);
      check("two/value", result, 64'h4000_0000_0000_0000);
      do_op("tiny_lsb", 57'd1 << 3, 1'b0, 1'b0, 1'b1, 13'd1023, 2'b00, 0, 1'b0);
      check("tiny_lsb/value", result, 64'h3cb0_0000_0000_0000);
      do_op("rne_up", {1'b0, 1'b1, 52'h1, 3'b100}, 1'b0, 1'b0, 1'b0, 13'd1023, 2'b00, 0, 1'b0);
      check("rne_up/value", result, 64'h3ff0_0000_0000_0002);
      do_op("rtz", {1'b0, 1'b1, 52'h1, 3'b100}, 1'b0, 1'b0, 1'b0, 13'd1023, 2'b01, 0, 1'b0);
      check("rtz/value", result, 64'h3ff0_0000_0000_0001);
      do_op("ovf_rne", 57'd1 << 56, 1'b0, 1'b0, 1'b0, 13'd2046, 2'b00, 0, 1'b0);
      check("ovf_rne/value", result, 64'h7ff0_0000_0000_0000);
      do_op("ovf_rtz", 57'd1 << 56, 1'b0, 1'b0, 1'b0, 13'd2046, 2'b01, 0, 1'b0);
      check("ovf_rtz/value", result, 64'h7fef_ffff_ffff_ffff);
      do_op("zero_rne", 57'd0, 1'b1, 1'b1, 1'b1, 13'd1023, 2'b00, 0, 1'b0);
      check("zero_rne/value", result, 64'h0000_0000_0000_0000);
      do_op("zero_rd", 57'd0, 1'b1, 1'b0, 1'b1, 13'd1023, 2'b11, 0, 1'b0);
      check("zero_rd/value", result, 64'h8000_0000_0000_0000);
      do_op("denorm", 57'd1 << 54, 1'b0, 1'b0, 1'b0, 13'd1, 2'b00, 0, 1'b0);
      check("denorm/value", result, 64'h0008_0000_0000_0000);
      do_op("carry", {2'b01, 53'h1f_ffff_ffff_ffff, 2'b11}, 1'b0, 1'b1, 1'b0, 13'd1023, 2'b11,
            0, 1'b0);
      do_op("hold", {1'b0, 1'b1, 52'h5, 3'b011}, 1'b0, 1'b1, 1'b0, 13'd700, 2'b10, 5, 1'b0);

      // Reset while normalizing: the in-flight operand must vanish.
      fs = 57'd1 << 3; fszero = 1'b0; ss1 = 1'b0; sx = 1'b0; es = 13'd1023; rm = 2'b00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_norm/in_ready", 64'(in_ready), 64'd1);
      check("rst_norm/out_valid", 64'(out_valid), 64'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      check("rst_norm/no_output", 64'(seen), 64'd0);

      for (int k = 0; k < 80; k++) begin
         pos  = $urandom_range(0, 56);
         mask = (57'd1 << (pos + 1)) - 57'd1;
         f    = 57'({$urandom, $urandom});
         f    = (f & mask) | (57'd1 << pos);
         if ($urandom_range(0, 7) == 0) f[55:2] = '1;
         case ($urandom_range(0, 3))
            0:       ex = 13'($urandom_range(1, 60));
            1:       ex = 13'($urandom_range(2035, 2046));
            default: ex = 13'($urandom_range(1, 2046));
         endcase
         do_op($sformatf("rand%0d", k), f, ($urandom_range(0, 9) == 0), 1'($urandom),
               1'($urandom), ex, 2'($urandom), 0, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sig_norm_round.md
Name: sig_norm_round

Overview:
- Post-add normalize-and-round stage of the double-precision FP adder.
- Consumes the significand adder's magnitude result, zero flag and result sign, plus the pre-normalization exponent.
- Normalizes with an iterative shifter and rounds per IEEE-754 mode.
- Returns a packed binary64 result and flags over a valid/ready handshake.

Parameters:
- EW, 13, signed internal exponent width (two's complement, biased by 1023).
- BIG_SHIFT, 8, left-shift step used while the top BIG_SHIFT significand bits are zero.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high, one clock
- in_valid  input  1  operand valid
- in_ready  output  1  stage can accept an operand
- fs  input  57  significand magnitude: bit56 weight 2, bit55 weight 1 (hidden), bits 2..0 guard/round/sticky
- fszero  input  1  sum is exactly zero
- ss1  input  1  result sign
- sx  input  1  effective subtraction
- es  input  EW  biased exponent of fs at bit55 weight
- rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RU (+inf), 11 RD (-inf)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  64  binary64 result
- inexact  output  1  rounding discarded nonzero bits
- overflow  output  1  result exceeded max finite
- underflow  output  1  tiny and inexact

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0. Reset mid-operation discards the in-flight operand; no output is produced for it.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture fs/fszero/ss1/sx/es/rm.
  - If fszero: go to DONE with result = signed zero, all flags 0.
    - Sign = (rm==11) when sx=1; sign = ss1 when sx=0.
  - Otherwise go to NORM.
- NORM, one action per cycle, first matching rule wins:
  - sig[56]=1: shift right 1, OR the shifted-out bit into sticky bit0, e+1; go to ROUND.
  - sig[55]=1: go to ROUND.
  - e<=1: go to ROUND; the result is denormal.
  - sig[55:48]==0 and e-8>=1: shift left 8, e-8.
  - Otherwise: shift left 1, e-1.
- ROUND, one cycle:
  - Mantissa = sig[55:3]; guard g=sig[2]; sticky st = sig[1]|sig[0].
  - Increment rules:
    - RNE: g & (st | sig[3]).
    - RTZ: never.
    - RU: (g|st) & ~sign.
    - RD: (g|st) & sign.
  - inexact = g|st.
  - If the increment carries into bit 56: renormalize right 1, e+1.
  - Denormal that rounds up into bit55: becomes normal with e=1.
  - Overflow when e>=2047: overflow=1, inexact=1.
    - Result is ±inf for RNE, for RU with sign=0, and for RD with sign=1.
    - Otherwise result is ±max finite 0x7FEFFFFFFFFFFFFF with the sign applied.
  - Exponent field = 0 if bit55 is clear after rounding, else e[10:0].
  - underflow = (exponent field==0) & inexact.
  - Go to DONE.
- DONE:
  - out_valid=1. result and flags stay stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid drops the next cycle.
- in_ready=0 in every state except IDLE. There is no overlap: a new capture can occur at the earliest one cycle after the handshake.
- Latency from capture to out_valid:
  - Zero: 1 cycle.
  - Normalized or carry-out input: 2 cycles.
  - Each extra NORM step: +1 cycle. Worst case is ≤15 cycles.
- out_ready held high while not in DONE has no effect.

Test Plan:
- fs=1<<56 (value 2.0), es=1023, ss1=0, rm=RNE -> result 0x4000000000000000, no flags, out_valid 2 cycles after capture.
- fs=1<<3, es=1023, sx=1 -> six 8-steps then four 1-steps, result 0x3CB0000000000000, exact, out_valid 12 cycles after capture.
- fs={1, 52'h0000000000001, g=1, r=0, s=0}, es=1023, RNE -> mantissa rounds up, result 0x3FF0000000000002, inexact=1. Same input with RTZ -> 0x3FF0000000000001.
- fs=1<<56, es=2046:
  - RNE -> 0x7FF0000000000000, overflow=1, inexact=1.
  - RTZ -> 0x7FEFFFFFFFFFFFFF.
- fszero=1, sx=1:
  - rm=RNE -> 0x0000000000000000.
  - rm=RD -> 0x8000000000000000.
  - Either case: out_valid 1 cycle after capture.
- Additional scenarios:
  - fs=1<<54, es=1 -> denormal 0x0008000000000000, underflow=0.
  - Hold out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0.
  - Assert rst in NORM -> next cycle IDLE, in_ready=1, out_valid=0, no output produced for the in-flight operand.
